// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed AD bus blocks (writer now, reader later).
package rtc_bus_pkg;

    localparam int unsigned TIMER_W     = 8;
    localparam int unsigned DEF_T_SETUP = 4;
    localparam int unsigned DEF_T_PULSE = 10;
    localparam int unsigned DEF_T_HOLD  = 4;

    localparam logic CS_IDLE = 1'b1;
    localparam logic WR_IDLE = 1'b1;
    localparam logic RD_IDLE = 1'b1;

    // RTC register map used by the setting controller
    localparam logic [7:0] RTC_REG_SEC   = 8'h20;
    localparam logic [7:0] RTC_REG_MIN   = 8'h21;
    localparam logic [7:0] RTC_REG_HOUR  = 8'h22;
    localparam logic [7:0] RTC_REG_DAY   = 8'h23;
    localparam logic [7:0] RTC_REG_MONTH = 8'h24;
    localparam logic [7:0] RTC_REG_YEAR  = 8'h25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD,
        ST_RELEASE
    } rtc_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } rtc_wr_req_t;

    // Timer reload value for a phase; a length of 0 still occupies one cycle
    function automatic logic [TIMER_W-1:0] phase_len_m1(input int unsigned len);
        return (len == 32'd0) ? TIMER_W'(0) : TIMER_W'(len - 32'd1);
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit phase down-counter with a registered zero flag.
module rtc_phase_timer
    import rtc_bus_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q;
    logic               zero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else if (load_i) begin
            count_q <= load_val_i;
            zero_q  <= (load_val_i == TIMER_W'(0));
        end else if (count_q != TIMER_W'(0)) begin
            count_q <= count_q - TIMER_W'(1);
            zero_q  <= (count_q == TIMER_W'(1));
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/rtc_ad_bus_writer.sv
// Writes one BCD byte to an RTC register as an address phase then a data phase on the AD bus.
// Optional RTC_BCD_CHECK_EN rejects requests whose digits are not valid BCD.
module rtc_ad_bus_writer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_PULSE = DEF_T_PULSE,
    parameter int unsigned T_HOLD  = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       a_d,
    output logic       wr_n,
    output logic       rd_n
);

    rtc_state_e         state_q, state_d;
    rtc_wr_req_t        req_q, req_d;
    logic               bcd_bad, accept, tmr_zero, tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               busy_q, done_q, ad_oe_q, cs_n_q, a_d_q, wr_n_q;
    logic [7:0]         ad_out_q;

`ifdef RTC_BCD_CHECK_EN
    assign bcd_bad = (digit1 > 4'd9) || (digit0 > 4'd9);
`else
    assign bcd_bad = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && start && !bcd_bad;

    always_comb begin
        req_d = req_q;
        if (accept) begin
            req_d.addr = addr;
            req_d.data = {digit1, digit0};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (accept)   state_d = ST_A_SETUP;
            ST_A_SETUP:  if (tmr_zero) state_d = ST_A_STROBE;
            ST_A_STROBE: if (tmr_zero) state_d = ST_A_HOLD;
            ST_A_HOLD:   if (tmr_zero) state_d = ST_D_SETUP;
            ST_D_SETUP:  if (tmr_zero) state_d = ST_D_STROBE;
            ST_D_STROBE: if (tmr_zero) state_d = ST_D_HOLD;
            ST_D_HOLD:   if (tmr_zero) state_d = ST_RELEASE;
            ST_RELEASE:                state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Timer is reloaded with the length of whichever state is being entered
    always_comb begin
        tmr_val = '0;
        case (state_d)
            ST_A_SETUP, ST_D_SETUP:   tmr_val = phase_len_m1(T_SETUP);
            ST_A_STROBE, ST_D_STROBE: tmr_val = phase_len_m1(T_PULSE);
            ST_A_HOLD, ST_D_HOLD:     tmr_val = phase_len_m1(T_HOLD);
            default:                  tmr_val = '0;
        endcase
    end

    assign tmr_load = (state_d != state_q);

    rtc_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Bus outputs are decoded from the next state so they register glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            cs_n_q   <= CS_IDLE;
            a_d_q    <= 1'b0;
            wr_n_q   <= WR_IDLE;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_RELEASE);
            wr_n_q  <= !((state_d == ST_A_STROBE) || (state_d == ST_D_STROBE));
            case (state_d)
                ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                    cs_n_q   <= 1'b0;
                    a_d_q    <= 1'b0;
                    ad_oe_q  <= 1'b1;
                    ad_out_q <= req_d.addr;
                end
                ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                    cs_n_q   <= 1'b0;
                    a_d_q    <= 1'b1;
                    ad_oe_q  <= 1'b1;
                    ad_out_q <= req_d.data;
                end
                default: begin
                    cs_n_q   <= CS_IDLE;
                    a_d_q    <= 1'b0;
                    ad_oe_q  <= 1'b0;
                    ad_out_q <= '0;
                end
            endcase
        end
    end

`ifdef RTC_BCD_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == ST_IDLE) && start && bcd_bad;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign cs_n   = cs_n_q;
    assign a_d    = a_d_q;
    assign wr_n   = wr_n_q;
    assign rd_n   = RD_IDLE;

endmodule

// File: tb/tb_rtc_ad_bus_writer.sv
// Directed bench for rtc_ad_bus_writer: default timing instance plus a minimum-timing instance.
module tb_rtc_ad_bus_writer;

    logic       clk, reset, start, start_f;
    logic [7:0] addr;
    logic [3:0] digit1, digit0;

    logic       busy, done, err, ad_oe, cs_n, a_d, wr_n, rd_n;
    logic [7:0] ad_out;
    logic       f_busy, f_done, f_err, f_ad_oe, f_cs_n, f_a_d, f_wr_n, f_rd_n;
    logic [7:0] f_ad_out;

    int vectors;
    int miscompares;

    logic [7:0] o_ad   [0:99];
    logic       o_oe   [0:99];
    logic       o_cs   [0:99];
    logic       o_ph   [0:99];
    logic       o_wr   [0:99];
    logic       o_rd   [0:99];
    logic       o_busy [0:99];
    logic       o_done [0:99];
    logic       o_err  [0:99];

    rtc_ad_bus_writer u_dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr),
        .digit1(digit1), .digit0(digit0), .busy(busy), .done(done), .err(err),
        .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .a_d(a_d), .wr_n(wr_n), .rd_n(rd_n)
    );

    rtc_ad_bus_writer #(.T_SETUP(0), .T_PULSE(1), .T_HOLD(0)) u_fast (
        .clk(clk), .reset(reset), .start(start_f), .addr(addr),
        .digit1(digit1), .digit0(digit0), .busy(f_busy), .done(f_done), .err(f_err),
        .ad_out(f_ad_out), .ad_oe(f_ad_oe), .cs_n(f_cs_n), .a_d(f_a_d), .wr_n(f_wr_n), .rd_n(f_rd_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic sample(input bit fast, input int i);
        o_ad[i]   = fast ? f_ad_out : ad_out;
        o_oe[i]   = fast ? f_ad_oe  : ad_oe;
        o_cs[i]   = fast ? f_cs_n   : cs_n;
        o_ph[i]   = fast ? f_a_d    : a_d;
        o_wr[i]   = fast ? f_wr_n   : wr_n;
        o_rd[i]   = fast ? f_rd_n   : rd_n;
        o_busy[i] = fast ? f_busy   : busy;
        o_done[i] = fast ? f_done   : done;
        o_err[i]  = fast ? f_err    : err;
    endtask

    // Records n cycles after the pending acceptance edge; inputs are scrambled after that edge
    task automatic capture(input bit fast, input int n, input int p1, input int p2, input bit hold,
                           input logic [7:0] na, input logic [3:0] n1, input logic [3:0] n0);
        sample(fast, 0);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            sample(fast, i);
            if (i == 1) begin
                addr   = na;
                digit1 = n1;
                digit0 = n0;
            end
            if (fast) start_f = hold || (i == p1) || (i == p2);
            else      start   = hold || (i == p1) || (i == p2);
        end
    endtask

    function automatic int cnt_phase(input int lo, input int hi, input logic [7:0] v, input logic ph);
        int c = 0;
        for (int i = lo; i <= hi; i++)
            if (o_cs[i] === 1'b0 && o_oe[i] === 1'b1 && o_ph[i] === ph && o_ad[i] === v) c++;
        return c;
    endfunction

    function automatic int cnt_wr(input int lo, input int hi, input logic ph);
        int c = 0;
        for (int i = lo; i <= hi; i++)
            if (o_wr[i] === 1'b0 && o_ph[i] === ph) c++;
        return c;
    endfunction

    function automatic int cnt_falls(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++)
            if (o_wr[i] === 1'b0 && o_wr[i-1] === 1'b1) c++;
        return c;
    endfunction

    function automatic int cnt_ones(input int lo, input int hi, input int which);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            case (which)
                0: if (o_busy[i] === 1'b1) c++;
                1: if (o_done[i] === 1'b1) c++;
                2: if (o_err[i]  === 1'b1) c++;
                3: if (o_rd[i]   === 1'b0) c++;
                default: if (o_cs[i] === 1'b0) c++;
            endcase
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        start   = 1'b0;
        start_f = 1'b0;
        addr    = 8'h00;
        digit1  = 4'h0;
        digit0  = 4'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ad_out", ad_out, 8'h00);
        chk("rst_ad_oe", ad_oe, 1'b0);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_a_d", a_d, 1'b0);
        chk("rst_wr_n", wr_n, 1'b1);
        chk("rst_rd_n", rd_n, 1'b1);
        chk("rst_fast_busy", f_busy, 1'b0);

        // Basic write at default timing
        addr = 8'h21; digit1 = 4'd5; digit0 = 4'd9; start = 1'b1;
        capture(0, 45, -1, -1, 0, 8'hFF, 4'h8, 4'h8);
        chk("t1_busy_first", o_busy[1], 1'b1);
        chk("t1_cs_first", o_cs[1], 1'b0);
        chk("t1_oe_first", o_oe[1], 1'b1);
        chk("t1_addr_cycles", cnt_phase(1, 45, 8'h21, 1'b0), 18);
        chk("t1_data_cycles", cnt_phase(1, 45, 8'h59, 1'b1), 18);
        chk("t1_wr_low_addr", cnt_wr(1, 45, 1'b0), 10);
        chk("t1_wr_low_data", cnt_wr(1, 45, 1'b1), 10);
        chk("t1_wr_before_fall", o_wr[4], 1'b1);
        chk("t1_wr_first_fall", o_wr[5], 1'b0);
        chk("t1_done_at_37", o_done[37], 1'b1);
        chk("t1_done_count", cnt_ones(1, 45, 1), 1);
        chk("t1_busy_len", cnt_ones(1, 45, 0), 37);
        chk("t1_busy_after", o_busy[38], 1'b0);
        chk("t1_rd_low", cnt_ones(0, 45, 3), 0);

        // Extra start pulses during an active write are ignored
        addr = 8'h30; digit1 = 4'd4; digit0 = 4'd2; start = 1'b1;
        capture(0, 45, 5, 20, 0, 8'h31, 4'd1, 4'd1);
        chk("t2_strobes", cnt_falls(1, 45), 2);
        chk("t2_busy_len", cnt_ones(1, 45, 0), 37);
        chk("t2_addr_cycles", cnt_phase(1, 45, 8'h30, 1'b0), 18);
        chk("t2_data_cycles", cnt_phase(1, 45, 8'h42, 1'b1), 18);

        // start held: one IDLE cycle between writes, each with its own inputs
        addr = 8'h22; digit1 = 4'd1; digit0 = 4'd2; start = 1'b1;
        capture(0, 80, -1, -1, 1, 8'h23, 4'd3, 4'd4);
        start = 1'b0;
        chk("t3_release_cs", o_cs[37], 1'b1);
        chk("t3_gap_busy", o_busy[38], 1'b0);
        chk("t3_gap_cs", o_cs[38], 1'b1);
        chk("t3_second_cs", o_cs[39], 1'b0);
        chk("t3_busy_total", cnt_ones(1, 76, 0), 74);
        chk("t3_w1_addr", cnt_phase(1, 37, 8'h22, 1'b0), 18);
        chk("t3_w1_data", cnt_phase(1, 37, 8'h12, 1'b1), 18);
        chk("t3_w2_addr", cnt_phase(39, 75, 8'h23, 1'b0), 18);
        chk("t3_w2_data", cnt_phase(39, 75, 8'h34, 1'b1), 18);
        repeat (40) tick();
        chk("t3_settled", busy, 1'b0);

        // Asynchronous reset during D_STROBE
        addr = 8'h25; digit1 = 4'd0; digit0 = 4'd7; start = 1'b1;
        capture(0, 25, -1, -1, 0, 8'hFF, 4'h8, 4'h8);
        chk("t4_in_dstrobe_wr", o_wr[25], 1'b0);
        chk("t4_in_dstrobe_ad", o_ph[25], 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_async_wr_n", wr_n, 1'b1);
        chk("t4_async_cs_n", cs_n, 1'b1);
        chk("t4_async_ad_oe", ad_oe, 1'b0);
        chk("t4_async_busy", busy, 1'b0);
        chk("t4_async_ad_out", ad_out, 8'h00);
        tick();
        reset = 1'b0;
        addr = 8'h26; digit1 = 4'd1; digit0 = 4'd1; start = 1'b1;
        capture(0, 45, -1, -1, 0, 8'hFF, 4'h8, 4'h8);
        chk("t4_rerun_busy", cnt_ones(1, 45, 0), 37);
        chk("t4_rerun_addr", cnt_phase(1, 45, 8'h26, 1'b0), 18);
        chk("t4_rerun_data", cnt_phase(1, 45, 8'h11, 1'b1), 18);
        chk("t4_rerun_done", o_done[37], 1'b1);

        // Minimum timing: zero-length setup/hold still take one cycle
        addr = 8'h27; digit1 = 4'd2; digit0 = 4'd3; start_f = 1'b1;
        capture(1, 10, -1, -1, 0, 8'hFF, 4'h8, 4'h8);
        chk("t5_busy_len", cnt_ones(1, 10, 0), 7);
        chk("t5_addr_cycles", cnt_phase(1, 10, 8'h27, 1'b0), 3);
        chk("t5_data_cycles", cnt_phase(1, 10, 8'h23, 1'b1), 3);
        chk("t5_wr_a_setup", o_wr[1], 1'b1);
        chk("t5_wr_a_strobe", o_wr[2], 1'b0);
        chk("t5_wr_d_strobe", o_wr[5], 1'b0);
        chk("t5_wr_low_total", cnt_wr(1, 10, 1'b0) + cnt_wr(1, 10, 1'b1), 2);
        chk("t5_done", o_done[7], 1'b1);
        chk("t5_idle_after", o_busy[8], 1'b0);

        // Non-BCD digits
        addr = 8'h24; digit1 = 4'hA; digit0 = 4'h3; start = 1'b1;
        capture(0, 45, -1, -1, 0, 8'hFF, 4'h8, 4'h8);
`ifdef RTC_BCD_CHECK_EN
        chk("t6_err_pulse", o_err[1], 1'b1);
        chk("t6_err_count", cnt_ones(1, 45, 2), 1);
        chk("t6_no_busy", cnt_ones(1, 45, 0), 0);
        chk("t6_no_cs", cnt_ones(1, 45, 4), 0);
`else
        chk("t6_err_none", cnt_ones(0, 45, 2), 0);
        chk("t6_busy_len", cnt_ones(1, 45, 0), 37);
        chk("t6_data_a3", cnt_phase(1, 45, 8'hA3, 1'b1), 18);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
